// File: rtl/cdb_pkg.sv
// Shared constants for the Common Data Bus arbiter: default widths, source indices, null tag.
package cdb_pkg;

  localparam int CDB_N_REQ   = 4;
  localparam int CDB_DATA_W  = 32;
  localparam int CDB_LABEL_W = 4;
  localparam int CDB_CNT_W   = 16;

  localparam int SRC_ALU = 0;
  localparam int SRC_MUL = 1;
  localparam int SRC_DIV = 2;
  localparam int SRC_LS  = 3;

  // Tag 0 marks "no producer"; a result carrying it must never be broadcast.
  localparam int LABEL_NONE = 0;

endpackage

// File: rtl/cdb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest set bit, rotate back.
// Zero latency; no state, so the caller owns the pointer.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic [N-1:0]  w_rot;
  logic [PW-1:0] w_off;

  always_comb begin
    w_rot = '0;
    w_off = '0;
    o_any = 1'b0;
    // Bit 0 of w_rot is the request at ptr, so the lowest set bit is the round-robin winner.
    for (int i = 0; i < N; i++) begin
      w_rot[i] = i_req[PW'(i) + i_ptr];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = PW'(i);
        o_any = 1'b1;
      end
    end
  end

  assign o_idx = w_off + i_ptr;
  assign o_gnt = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Round-robin Common Data Bus arbiter: combinational one-hot grant, broadcast registered one cycle later.
// Requesters hold their result until granted; a tag-0 result is drained without broadcast and flagged.
module cdb_rr_arbiter
  import cdb_pkg::*;
#(
  parameter int N_REQ   = CDB_N_REQ,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int LABEL_W = CDB_LABEL_W,
  parameter int CNT_W   = CDB_CNT_W
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic [N_REQ-1:0]           require,
  input  logic [N_REQ*DATA_W-1:0]    dataIn,
  input  logic [N_REQ*LABEL_W-1:0]   labelIn,
  output logic [N_REQ-1:0]           requireAC,
  output logic                       BCEN,
  output logic [DATA_W-1:0]          BCdata,
  output logic [LABEL_W-1:0]         BClabel,
  output logic                       errLabel,
  output logic [CNT_W-1:0]           bcCount
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]   r_ptr;
  logic               r_bcen;
  logic [DATA_W-1:0]  r_bcdata;
  logic [LABEL_W-1:0] r_bclabel;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;

  logic [N_REQ-1:0]   w_gnt;
  logic [PTR_W-1:0]   w_idx;
  logic               w_any;
  logic [DATA_W-1:0]  w_data;
  logic [LABEL_W-1:0] w_label;
  logic               w_null;

  rr_pick #(.N(N_REQ), .PW(PTR_W)) u_pick (
    .i_req (require),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Grant is gated by reset so no requester sees an acknowledge that the registers will discard.
  assign requireAC = nRST ? w_gnt : '0;
  assign w_data    = dataIn[w_idx*DATA_W +: DATA_W];
  assign w_label   = labelIn[w_idx*LABEL_W +: LABEL_W];
  assign w_null    = (w_label == LABEL_W'(LABEL_NONE));

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_ptr     <= '0;
      r_bcen    <= 1'b0;
      r_bcdata  <= '0;
      r_bclabel <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_any) begin
        r_ptr     <= w_idx + PTR_W'(1);
        r_bcdata  <= w_data;
        r_bclabel <= w_label;
        r_bcen    <= !w_null;
        if (w_null) begin
          r_err <= 1'b1;
        end
      end else begin
        r_bcen    <= 1'b0;
        r_bcdata  <= '0;
        r_bclabel <= '0;
      end
      if (w_any && !w_null && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign BCEN     = r_bcen;
  assign BCdata   = r_bcdata;
  assign BClabel  = r_bclabel;
  assign errLabel = r_err;
  assign bcCount  = r_cnt;

endmodule
